// File: rtl/id_pkg.sv
// Shared encodings for the ID stage: MIPS-I opcode/funct/regimm fields,
// ALU operation codes and the decoded control bundle.
package id_pkg;

    localparam int REG_COUNT = 32;

    localparam logic [5:0] OPC_SPECIAL = 6'h00;
    localparam logic [5:0] OPC_REGIMM  = 6'h01;
    localparam logic [5:0] OPC_J       = 6'h02;
    localparam logic [5:0] OPC_JAL     = 6'h03;
    localparam logic [5:0] OPC_BEQ     = 6'h04;
    localparam logic [5:0] OPC_BNE     = 6'h05;
    localparam logic [5:0] OPC_BLEZ    = 6'h06;
    localparam logic [5:0] OPC_BGTZ    = 6'h07;
    localparam logic [5:0] OPC_ADDI    = 6'h08;
    localparam logic [5:0] OPC_ADDIU   = 6'h09;
    localparam logic [5:0] OPC_SLTI    = 6'h0A;
    localparam logic [5:0] OPC_SLTIU   = 6'h0B;
    localparam logic [5:0] OPC_ANDI    = 6'h0C;
    localparam logic [5:0] OPC_ORI     = 6'h0D;
    localparam logic [5:0] OPC_XORI    = 6'h0E;
    localparam logic [5:0] OPC_LUI     = 6'h0F;
    localparam logic [5:0] OPC_LB      = 6'h20;
    localparam logic [5:0] OPC_LH      = 6'h21;
    localparam logic [5:0] OPC_LW      = 6'h23;
    localparam logic [5:0] OPC_LBU     = 6'h24;
    localparam logic [5:0] OPC_LHU     = 6'h25;
    localparam logic [5:0] OPC_SB      = 6'h28;
    localparam logic [5:0] OPC_SH      = 6'h29;
    localparam logic [5:0] OPC_SW      = 6'h2B;
    localparam logic [5:0] OPC_LL      = 6'h30;
    localparam logic [5:0] OPC_SC      = 6'h38;

    localparam logic [5:0] FUNCT_SLL     = 6'h00;
    localparam logic [5:0] FUNCT_SRL     = 6'h02;
    localparam logic [5:0] FUNCT_SRA     = 6'h03;
    localparam logic [5:0] FUNCT_SLLV    = 6'h04;
    localparam logic [5:0] FUNCT_SRLV    = 6'h06;
    localparam logic [5:0] FUNCT_SRAV    = 6'h07;
    localparam logic [5:0] FUNCT_JR      = 6'h08;
    localparam logic [5:0] FUNCT_JALR    = 6'h09;
    localparam logic [5:0] FUNCT_SYSCALL = 6'h0C;
    localparam logic [5:0] FUNCT_MFHI    = 6'h10;
    localparam logic [5:0] FUNCT_MTHI    = 6'h11;
    localparam logic [5:0] FUNCT_MFLO    = 6'h12;
    localparam logic [5:0] FUNCT_MTLO    = 6'h13;
    localparam logic [5:0] FUNCT_MULT    = 6'h18;
    localparam logic [5:0] FUNCT_MULTU   = 6'h19;
    localparam logic [5:0] FUNCT_DIV     = 6'h1A;
    localparam logic [5:0] FUNCT_DIVU    = 6'h1B;
    localparam logic [5:0] FUNCT_ADD     = 6'h20;
    localparam logic [5:0] FUNCT_ADDU    = 6'h21;
    localparam logic [5:0] FUNCT_SUB     = 6'h22;
    localparam logic [5:0] FUNCT_SUBU    = 6'h23;
    localparam logic [5:0] FUNCT_AND     = 6'h24;
    localparam logic [5:0] FUNCT_OR      = 6'h25;
    localparam logic [5:0] FUNCT_XOR     = 6'h26;
    localparam logic [5:0] FUNCT_NOR     = 6'h27;
    localparam logic [5:0] FUNCT_SLT     = 6'h2A;
    localparam logic [5:0] FUNCT_SLTU    = 6'h2B;

    localparam logic [4:0] REGIMM_RT_BLTZ   = 5'h00;
    localparam logic [4:0] REGIMM_RT_BGEZ   = 5'h01;
    localparam logic [4:0] REGIMM_RT_BLTZAL = 5'h10;
    localparam logic [4:0] REGIMM_RT_BGEZAL = 5'h11;

    localparam logic [5:0] ALU_NOP     = 6'h00;
    localparam logic [5:0] ALU_ADD     = 6'h01;
    localparam logic [5:0] ALU_ADDU    = 6'h02;
    localparam logic [5:0] ALU_SUB     = 6'h03;
    localparam logic [5:0] ALU_SUBU    = 6'h04;
    localparam logic [5:0] ALU_AND     = 6'h05;
    localparam logic [5:0] ALU_OR      = 6'h06;
    localparam logic [5:0] ALU_XOR     = 6'h07;
    localparam logic [5:0] ALU_NOR     = 6'h08;
    localparam logic [5:0] ALU_SLT     = 6'h09;
    localparam logic [5:0] ALU_SLTU    = 6'h0A;
    localparam logic [5:0] ALU_SLL     = 6'h0B;
    localparam logic [5:0] ALU_SRL     = 6'h0C;
    localparam logic [5:0] ALU_SRA     = 6'h0D;
    localparam logic [5:0] ALU_SLLV    = 6'h0E;
    localparam logic [5:0] ALU_SRLV    = 6'h0F;
    localparam logic [5:0] ALU_SRAV    = 6'h10;
    localparam logic [5:0] ALU_JR      = 6'h11;
    localparam logic [5:0] ALU_JALR    = 6'h12;
    localparam logic [5:0] ALU_SYSCALL = 6'h13;
    localparam logic [5:0] ALU_MULT    = 6'h14;
    localparam logic [5:0] ALU_MULTU   = 6'h15;
    localparam logic [5:0] ALU_DIV     = 6'h16;
    localparam logic [5:0] ALU_DIVU    = 6'h17;
    localparam logic [5:0] ALU_MFHI    = 6'h18;
    localparam logic [5:0] ALU_MFLO    = 6'h19;
    localparam logic [5:0] ALU_MTHI    = 6'h1A;
    localparam logic [5:0] ALU_MTLO    = 6'h1B;
    localparam logic [5:0] ALU_ADDI    = 6'h1C;
    localparam logic [5:0] ALU_ADDIU   = 6'h1D;
    localparam logic [5:0] ALU_SLTI    = 6'h1E;
    localparam logic [5:0] ALU_SLTIU   = 6'h1F;
    localparam logic [5:0] ALU_ANDI    = 6'h20;
    localparam logic [5:0] ALU_ORI     = 6'h21;
    localparam logic [5:0] ALU_XORI    = 6'h22;
    localparam logic [5:0] ALU_LUI     = 6'h23;
    localparam logic [5:0] ALU_LB      = 6'h24;
    localparam logic [5:0] ALU_LBU     = 6'h25;
    localparam logic [5:0] ALU_LH      = 6'h26;
    localparam logic [5:0] ALU_LHU     = 6'h27;
    localparam logic [5:0] ALU_LL      = 6'h28;
    localparam logic [5:0] ALU_LW      = 6'h29;
    localparam logic [5:0] ALU_SB      = 6'h2A;
    localparam logic [5:0] ALU_SH      = 6'h2B;
    localparam logic [5:0] ALU_SW      = 6'h2C;
    localparam logic [5:0] ALU_J       = 6'h2D;
    localparam logic [5:0] ALU_JAL     = 6'h2E;
    localparam logic [5:0] ALU_BEQ     = 6'h2F;
    localparam logic [5:0] ALU_BNE     = 6'h30;
    localparam logic [5:0] ALU_BLEZ    = 6'h31;
    localparam logic [5:0] ALU_BGTZ    = 6'h32;
    localparam logic [5:0] ALU_BLTZ    = 6'h33;
    localparam logic [5:0] ALU_BGEZ    = 6'h34;
    localparam logic [5:0] ALU_BLTZAL  = 6'h35;
    localparam logic [5:0] ALU_SC      = 6'h36;
    localparam logic [5:0] ALU_BGEZAL  = 6'h37;

    typedef struct packed {
        logic link;
        logic reg_dest;
        logic jump;
        logic branch;
        logic mem_read;
        logic mem_write;
        logic alu_src;
        logic reg_write;
        logic jump_register;
        logic sign_or_zero;
        logic syscall;
        logic mult_reg_access;
    } ctrl_t;

endpackage

// File: rtl/id_regfile.sv
// 32x32 architectural register file: three combinational read ports,
// one synchronous write port, r0 hardwired to zero, no write bypass.
module id_regfile
    import id_pkg::*;
(
    input  logic        CLK,
    input  logic        RESET,
    input  logic [4:0]  RegA,
    input  logic [4:0]  RegB,
    input  logic [4:0]  RegC,
    input  logic [4:0]  WriteReg,
    input  logic [31:0] WriteData,
    input  logic        Write,
    output logic [31:0] DataA,
    output logic [31:0] DataB,
    output logic [31:0] DataC
);

    logic [31:0] regs [REG_COUNT];

    // Clear on reset (wins over a write); otherwise commit write-back.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regs[i] <= '0;
            end
        end else if (Write && (WriteReg != 5'd0)) begin
            regs[WriteReg] <= WriteData;
        end
    end

    assign DataA = (RegA == 5'd0) ? 32'd0 : regs[RegA];
    assign DataB = (RegB == 5'd0) ? 32'd0 : regs[RegB];
    assign DataC = (RegC == 5'd0) ? 32'd0 : regs[RegC];

endmodule

// File: rtl/id_decode_core.sv
// ID-stage core: instruction decoder, branch/jump target calculator
// and the architectural register file.
module id_decode_core
    import id_pkg::*;
(
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] Instr,
    input  logic [31:0] Instr_PC_Plus4,
    input  logic [31:0] RegisterValue,
    input  logic [4:0]  RegA,
    input  logic [4:0]  RegB,
    input  logic [4:0]  RegC,
    input  logic [4:0]  WriteReg,
    input  logic [31:0] WriteData,
    input  logic        Write,
    output logic [31:0] DataA,
    output logic [31:0] DataB,
    output logic [31:0] DataC,
    output logic [31:0] NextInstructionAddress,
    output logic        Link,
    output logic        RegDest,
    output logic        Jump,
    output logic        Branch,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        ALUSrc,
    output logic        RegWrite,
    output logic        JumpRegister,
    output logic        SignOrZero,
    output logic        Syscall,
    output logic        MultRegAccess,
    output logic [5:0]  ALUControl
);

    logic [5:0]  opc;
    logic [5:0]  funct;
    logic [4:0]  rt;
    logic [31:0] br_off;
    ctrl_t       c;
    logic [5:0]  alu;
    logic        r_alu, i_alu, i_zx, ld, st, br, mf, md;

    assign opc    = Instr[31:26];
    assign funct  = Instr[5:0];
    assign rt     = Instr[20:16];
    assign br_off = {{14{Instr[15]}}, Instr[15:0], 2'b00};

    // Decode opcode/funct into an ALU code and an instruction class,
    // then expand the class into control flags.
    always_comb begin
        c = '0;
        alu = ALU_NOP;
        r_alu = 1'b0;
        i_alu = 1'b0;
        i_zx = 1'b0;
        ld = 1'b0;
        st = 1'b0;
        br = 1'b0;
        mf = 1'b0;
        md = 1'b0;
        unique case (opc)
            OPC_SPECIAL: begin
                unique case (funct)
                    FUNCT_ADD:  begin alu = ALU_ADD;  r_alu = 1'b1; end
                    FUNCT_ADDU: begin alu = ALU_ADDU; r_alu = 1'b1; end
                    FUNCT_SUB:  begin alu = ALU_SUB;  r_alu = 1'b1; end
                    FUNCT_SUBU: begin alu = ALU_SUBU; r_alu = 1'b1; end
                    FUNCT_AND:  begin alu = ALU_AND;  r_alu = 1'b1; end
                    FUNCT_OR:   begin alu = ALU_OR;   r_alu = 1'b1; end
                    FUNCT_XOR:  begin alu = ALU_XOR;  r_alu = 1'b1; end
                    FUNCT_NOR:  begin alu = ALU_NOR;  r_alu = 1'b1; end
                    FUNCT_SLT:  begin alu = ALU_SLT;  r_alu = 1'b1; end
                    FUNCT_SLTU: begin alu = ALU_SLTU; r_alu = 1'b1; end
                    FUNCT_SLL:  begin alu = ALU_SLL;  r_alu = 1'b1; end
                    FUNCT_SRL:  begin alu = ALU_SRL;  r_alu = 1'b1; end
                    FUNCT_SRA:  begin alu = ALU_SRA;  r_alu = 1'b1; end
                    FUNCT_SLLV: begin alu = ALU_SLLV; r_alu = 1'b1; end
                    FUNCT_SRLV: begin alu = ALU_SRLV; r_alu = 1'b1; end
                    FUNCT_SRAV: begin alu = ALU_SRAV; r_alu = 1'b1; end
                    FUNCT_MULT:  begin alu = ALU_MULT;  md = 1'b1; end
                    FUNCT_MULTU: begin alu = ALU_MULTU; md = 1'b1; end
                    FUNCT_DIV:   begin alu = ALU_DIV;   md = 1'b1; end
                    FUNCT_DIVU:  begin alu = ALU_DIVU;  md = 1'b1; end
                    FUNCT_MTHI:  begin alu = ALU_MTHI;  md = 1'b1; end
                    FUNCT_MTLO:  begin alu = ALU_MTLO;  md = 1'b1; end
                    FUNCT_MFHI:  begin alu = ALU_MFHI;  mf = 1'b1; end
                    FUNCT_MFLO:  begin alu = ALU_MFLO;  mf = 1'b1; end
                    FUNCT_SYSCALL: begin
                        alu = ALU_SYSCALL;
                        c.syscall = 1'b1;
                    end
                    FUNCT_JR: begin
                        alu = ALU_JR;
                        c.jump = 1'b1;
                        c.jump_register = 1'b1;
                    end
                    FUNCT_JALR: begin
                        alu = ALU_JALR;
                        c.jump = 1'b1;
                        c.jump_register = 1'b1;
                        c.link = 1'b1;
                        c.reg_dest = 1'b1;
                        c.reg_write = 1'b1;
                    end
                    default: ;
                endcase
            end
            OPC_REGIMM: begin
                unique case (rt)
                    REGIMM_RT_BLTZ: begin alu = ALU_BLTZ; br = 1'b1; end
                    REGIMM_RT_BGEZ: begin alu = ALU_BGEZ; br = 1'b1; end
                    REGIMM_RT_BLTZAL: begin
                        alu = ALU_BLTZAL;
                        br = 1'b1;
                        c.link = 1'b1;
                        c.reg_write = 1'b1;
                    end
                    REGIMM_RT_BGEZAL: begin
                        alu = ALU_BGEZAL;
                        br = 1'b1;
                        c.link = 1'b1;
                        c.reg_write = 1'b1;
                    end
                    default: ;
                endcase
            end
            OPC_J:   begin alu = ALU_J; c.jump = 1'b1; end
            OPC_JAL: begin
                alu = ALU_JAL;
                c.jump = 1'b1;
                c.link = 1'b1;
                c.reg_write = 1'b1;
            end
            OPC_BEQ:   begin alu = ALU_BEQ;  br = 1'b1; end
            OPC_BNE:   begin alu = ALU_BNE;  br = 1'b1; end
            OPC_BLEZ:  begin alu = ALU_BLEZ; br = 1'b1; end
            OPC_BGTZ:  begin alu = ALU_BGTZ; br = 1'b1; end
            OPC_ADDI:  begin alu = ALU_ADDI;  i_alu = 1'b1; end
            OPC_ADDIU: begin alu = ALU_ADDIU; i_alu = 1'b1; end
            OPC_SLTI:  begin alu = ALU_SLTI;  i_alu = 1'b1; end
            OPC_SLTIU: begin alu = ALU_SLTIU; i_alu = 1'b1; end
            OPC_LUI:   begin alu = ALU_LUI;   i_alu = 1'b1; end
            OPC_ANDI:  begin alu = ALU_ANDI; i_alu = 1'b1; i_zx = 1'b1; end
            OPC_ORI:   begin alu = ALU_ORI;  i_alu = 1'b1; i_zx = 1'b1; end
            OPC_XORI:  begin alu = ALU_XORI; i_alu = 1'b1; i_zx = 1'b1; end
            OPC_LB:    begin alu = ALU_LB;  ld = 1'b1; end
            OPC_LBU:   begin alu = ALU_LBU; ld = 1'b1; end
            OPC_LH:    begin alu = ALU_LH;  ld = 1'b1; end
            OPC_LHU:   begin alu = ALU_LHU; ld = 1'b1; end
            OPC_LW:    begin alu = ALU_LW;  ld = 1'b1; end
            OPC_LL: begin
                alu = ALU_LL;
                ld = 1'b1;
                c.syscall = 1'b1;
            end
            OPC_SB: begin alu = ALU_SB; st = 1'b1; end
            OPC_SH: begin alu = ALU_SH; st = 1'b1; end
            OPC_SW: begin alu = ALU_SW; st = 1'b1; end
            OPC_SC: begin
                alu = ALU_SC;
                st = 1'b1;
                c.reg_write = 1'b1;
                c.syscall = 1'b1;
            end
            default: ;
        endcase
        if (r_alu || mf) begin
            c.reg_dest = 1'b1;
            c.reg_write = 1'b1;
        end
        if (mf || md) begin
            c.mult_reg_access = 1'b1;
        end
        if (i_alu) begin
            c.alu_src = 1'b1;
            c.reg_write = 1'b1;
            c.sign_or_zero = !i_zx;
        end
        if (ld) begin
            c.mem_read = 1'b1;
            c.alu_src = 1'b1;
            c.reg_write = 1'b1;
            c.sign_or_zero = 1'b1;
        end
        if (st) begin
            c.mem_write = 1'b1;
            c.alu_src = 1'b1;
            c.sign_or_zero = 1'b1;
        end
        if (br) begin
            c.branch = 1'b1;
            c.sign_or_zero = 1'b1;
        end
    end

    // Target select: register jump, then pseudo-direct jump, else PC-relative.
    always_comb begin
        if (c.jump_register) begin
            NextInstructionAddress = RegisterValue;
        end else if (c.jump) begin
            NextInstructionAddress = {Instr_PC_Plus4[31:28], Instr[25:0], 2'b00};
        end else begin
            NextInstructionAddress = Instr_PC_Plus4 + br_off;
        end
    end

    assign Link          = c.link;
    assign RegDest       = c.reg_dest;
    assign Jump          = c.jump;
    assign Branch        = c.branch;
    assign MemRead       = c.mem_read;
    assign MemWrite      = c.mem_write;
    assign ALUSrc        = c.alu_src;
    assign RegWrite      = c.reg_write;
    assign JumpRegister  = c.jump_register;
    assign SignOrZero    = c.sign_or_zero;
    assign Syscall       = c.syscall;
    assign MultRegAccess = c.mult_reg_access;
    assign ALUControl    = alu;

    id_regfile u_regfile (
        .CLK       (CLK),
        .RESET     (RESET),
        .RegA      (RegA),
        .RegB      (RegB),
        .RegC      (RegC),
        .WriteReg  (WriteReg),
        .WriteData (WriteData),
        .Write     (Write),
        .DataA     (DataA),
        .DataB     (DataB),
        .DataC     (DataC)
    );

endmodule

// File: tb/tb_id_decode_core.sv
// Bench for id_decode_core: register file behaviour and decoder /
// target-address table, checked against a queue of expected results.
module tb_id_decode_core;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic [31:0] Instr = '0;
    logic [31:0] Instr_PC_Plus4 = '0;
    logic [31:0] RegisterValue = '0;
    logic [4:0]  RegA = '0;
    logic [4:0]  RegB = '0;
    logic [4:0]  RegC = '0;
    logic [4:0]  WriteReg = '0;
    logic [31:0] WriteData = '0;
    logic        Write = 1'b0;
    logic [31:0] DataA, DataB, DataC, NextInstructionAddress;
    logic        Link, RegDest, Jump, Branch, MemRead, MemWrite;
    logic        ALUSrc, RegWrite, JumpRegister, SignOrZero, Syscall;
    logic        MultRegAccess;
    logic [5:0]  ALUControl;
    logic [11:0] flags;

    int n_checks = 0;
    int n_fail = 0;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc4;
        logic [31:0] rv;
        logic [31:0] nia;
        logic [11:0] fl;
        logic [5:0]  alu;
    } dec_t;

    logic [31:0] rq [$];
    dec_t        dq [$];
    logic [31:0] model [32];

    always #5 CLK = ~CLK;

    assign flags = {Link, RegDest, Jump, Branch, MemRead, MemWrite,
                    ALUSrc, RegWrite, JumpRegister, SignOrZero,
                    Syscall, MultRegAccess};

    id_decode_core dut (
        .CLK                    (CLK),
        .RESET                  (RESET),
        .Instr                  (Instr),
        .Instr_PC_Plus4         (Instr_PC_Plus4),
        .RegisterValue          (RegisterValue),
        .RegA                   (RegA),
        .RegB                   (RegB),
        .RegC                   (RegC),
        .WriteReg               (WriteReg),
        .WriteData              (WriteData),
        .Write                  (Write),
        .DataA                  (DataA),
        .DataB                  (DataB),
        .DataC                  (DataC),
        .NextInstructionAddress (NextInstructionAddress),
        .Link                   (Link),
        .RegDest                (RegDest),
        .Jump                   (Jump),
        .Branch                 (Branch),
        .MemRead                (MemRead),
        .MemWrite               (MemWrite),
        .ALUSrc                 (ALUSrc),
        .RegWrite               (RegWrite),
        .JumpRegister           (JumpRegister),
        .SignOrZero             (SignOrZero),
        .Syscall                (Syscall),
        .MultRegAccess          (MultRegAccess),
        .ALUControl             (ALUControl)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        logic [31:0] e;
        RESET = 1'b1;
        Write = 1'b1;
        WriteReg = 5'd9;
        WriteData = 32'hFFFF_FFFF;
        tick();
        RESET = 1'b0;
        Write = 1'b0;
        for (int i = 1; i < 32; i++) begin
            RegA = 5'(i);
            rq.push_back(32'd0);
            #1;
            e = rq.pop_front();
            n_checks++;
            if (DataA !== e) begin
                n_fail++;
                $display("FAIL reset_r%0d got %h exp %h", i, DataA, e);
            end
        end
    endtask

    task automatic test_write_read();
        logic [31:0] e;
        Write = 1'b1;
        WriteReg = 5'd5;
        WriteData = 32'hDEAD_BEEF;
        RegA = 5'd5;
        tick();
        Write = 1'b0;
        rq.push_back(32'hDEAD_BEEF);
        #1;
        e = rq.pop_front();
        n_checks++;
        if (DataA !== e) begin
            n_fail++;
            $display("FAIL write_r5 got %h exp %h", DataA, e);
        end
    endtask

    task automatic test_r0();
        logic [31:0] e;
        Write = 1'b1;
        WriteReg = 5'd0;
        WriteData = 32'h0000_1234;
        RegB = 5'd0;
        tick();
        Write = 1'b0;
        rq.push_back(32'd0);
        #1;
        e = rq.pop_front();
        n_checks++;
        if (DataB !== e) begin
            n_fail++;
            $display("FAIL r0_write got %h exp %h", DataB, e);
        end
    endtask

    task automatic test_no_bypass();
        logic [31:0] e;
        Write = 1'b1;
        WriteReg = 5'd7;
        WriteData = 32'hA5A5_5A5A;
        RegC = 5'd7;
        rq.push_back(32'd0);
        #1;
        e = rq.pop_front();
        n_checks++;
        if (DataC !== e) begin
            n_fail++;
            $display("FAIL r7_same_cycle got %h exp %h", DataC, e);
        end
        rq.push_back(32'hA5A5_5A5A);
        tick();
        Write = 1'b0;
        #1;
        e = rq.pop_front();
        n_checks++;
        if (DataC !== e) begin
            n_fail++;
            $display("FAIL r7_next_cycle got %h exp %h", DataC, e);
        end
    endtask

    task automatic test_reset_priority();
        logic [31:0] e;
        Write = 1'b1;
        WriteReg = 5'd10;
        WriteData = 32'h1111_2222;
        tick();
        RESET = 1'b1;
        WriteData = 32'h3333_4444;
        tick();
        RESET = 1'b0;
        Write = 1'b0;
        RegA = 5'd10;
        RegB = 5'd5;
        RegC = 5'd7;
        rq.push_back(32'd0);
        rq.push_back(32'd0);
        rq.push_back(32'd0);
        #1;
        e = rq.pop_front();
        n_checks++;
        if (DataA !== e) begin
            n_fail++;
            $display("FAIL rst_prio_r10 got %h exp %h", DataA, e);
        end
        e = rq.pop_front();
        n_checks++;
        if (DataB !== e) begin
            n_fail++;
            $display("FAIL rst_clear_r5 got %h exp %h", DataB, e);
        end
        e = rq.pop_front();
        n_checks++;
        if (DataC !== e) begin
            n_fail++;
            $display("FAIL rst_clear_r7 got %h exp %h", DataC, e);
        end
    endtask

    task automatic test_random_rf();
        logic [31:0] e;
        logic [4:0]  a;
        logic [31:0] d;
        for (int i = 0; i < 32; i++) model[i] = 32'd0;
        for (int i = 0; i < 40; i++) begin
            a = 5'($urandom_range(0, 31));
            d = $urandom;
            Write = 1'b1;
            WriteReg = a;
            WriteData = d;
            RegA = a;
            rq.push_back(model[a]);
            #1;
            e = rq.pop_front();
            n_checks++;
            if (DataA !== e) begin
                n_fail++;
                $display("FAIL rand_old[%0d] r%0d got %h exp %h", i, a, DataA, e);
            end
            if (a != 5'd0) model[a] = d;
            rq.push_back(model[a]);
            tick();
            Write = 1'b0;
            RegB = a;
            RegC = 5'($urandom_range(0, 31));
            #1;
            e = rq.pop_front();
            n_checks++;
            if (DataB !== e) begin
                n_fail++;
                $display("FAIL rand_new[%0d] r%0d got %h exp %h", i, a, DataB, e);
            end
            n_checks++;
            if (DataC !== model[RegC]) begin
                n_fail++;
                $display("FAIL rand_c[%0d] r%0d got %h exp %h", i, RegC, DataC, model[RegC]);
            end
        end
    endtask

    task automatic test_decode();
        dec_t tbl [$];
        dec_t x;
        dec_t e;
        tbl.push_back('{32'h0C000010, 32'h40000004, 32'h0, 32'h40000040, 12'hA10, 6'h2E});
        tbl.push_back('{32'h1000FFFF, 32'h00000100, 32'h0, 32'h000000FC, 12'h104, 6'h2F});
        tbl.push_back('{32'h03E00008, 32'h00000100, 32'h00400020, 32'h00400020, 12'h208, 6'h11});
        tbl.push_back('{32'hC0000000, 32'h00000100, 32'h0, 32'h00000100, 12'h0B6, 6'h28});
        tbl.push_back('{32'hFC000000, 32'h00000100, 32'h0, 32'h00000100, 12'h000, 6'h00});
        tbl.push_back('{32'h00000000, 32'h00000100, 32'h0, 32'h00000100, 12'h410, 6'h0B});
        tbl.push_back('{32'h00221821, 32'h00000100, 32'h0, 32'h00006184, 12'h410, 6'h02});
        tbl.push_back('{32'h3401FFFF, 32'h00000100, 32'h0, 32'h000000FC, 12'h030, 6'h21});
        tbl.push_back('{32'h2001FFFF, 32'h00000100, 32'h0, 32'h000000FC, 12'h034, 6'h1C});
        tbl.push_back('{32'hAC010008, 32'h00000100, 32'h0, 32'h00000120, 12'h064, 6'h2C});
        tbl.push_back('{32'hE0010000, 32'h00000100, 32'h0, 32'h00000100, 12'h076, 6'h36});
        tbl.push_back('{32'h04110004, 32'h00000100, 32'h0, 32'h00000110, 12'h914, 6'h37});
        tbl.push_back('{32'h0040F809, 32'h00000100, 32'h00001234, 32'h00001234, 12'hE18, 6'h12});
        tbl.push_back('{32'h00002010, 32'h00000100, 32'h0, 32'h00008140, 12'h411, 6'h18});
        tbl.push_back('{32'h00220018, 32'h00000100, 32'h0, 32'h00000160, 12'h001, 6'h14});
        tbl.push_back('{32'h0000000C, 32'h00000100, 32'h0, 32'h00000130, 12'h002, 6'h13});
        tbl.push_back('{32'h08000100, 32'hF0000000, 32'h0, 32'hF0000400, 12'h200, 6'h2D});
        tbl.push_back('{32'h14007FFF, 32'hFFFFFFF0, 32'h0, 32'h0001FFEC, 12'h104, 6'h30});
        tbl.push_back('{32'h00000001, 32'h00000100, 32'h0, 32'h00000104, 12'h000, 6'h00});
        tbl.push_back('{32'h04020000, 32'h00000100, 32'h0, 32'h00000100, 12'h000, 6'h00});
        tbl.push_back('{32'h3C011234, 32'h00000100, 32'h0, 32'h000049D0, 12'h034, 6'h23});
        tbl.push_back('{32'h90220004, 32'h00000100, 32'h0, 32'h00000110, 12'h0B4, 6'h25});
        for (int i = 0; i < tbl.size(); i++) begin
            x = tbl[i];
            Instr = x.instr;
            Instr_PC_Plus4 = x.pc4;
            RegisterValue = x.rv;
            dq.push_back(x);
            #2;
            e = dq.pop_front();
            n_checks++;
            if (NextInstructionAddress !== e.nia) begin
                n_fail++;
                $display("FAIL dec[%0d] %h nia got %h exp %h", i, e.instr, NextInstructionAddress, e.nia);
            end
            n_checks++;
            if (flags !== e.fl) begin
                n_fail++;
                $display("FAIL dec[%0d] %h flags got %h exp %h", i, e.instr, flags, e.fl);
            end
            n_checks++;
            if (ALUControl !== e.alu) begin
                n_fail++;
                $display("FAIL dec[%0d] %h alu got %h exp %h", i, e.instr, ALUControl, e.alu);
            end
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        tick();
        test_reset();
        test_write_read();
        test_r0();
        test_no_bypass();
        test_reset_priority();
        test_random_rf();
        test_decode();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
